// File: rtl/cas_stream_if.sv
// Handshake and data bundle for one compare-and-swap node: producer side
// drives keys/tags/mode, consumer side returns ordered keys.
interface cas_stream_if #(
    parameter int DATAWIDTH = 8,
    parameter int IDXWIDTH  = 4
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 sign_i;
    logic                 desc_i;
    logic [DATAWIDTH-1:0] x1_i;
    logic [DATAWIDTH-1:0] x2_i;
    logic [IDXWIDTH-1:0]  x1_idx_i;
    logic [IDXWIDTH-1:0]  x2_idx_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DATAWIDTH-1:0] y1_o;
    logic [DATAWIDTH-1:0] y2_o;
    logic [IDXWIDTH-1:0]  y1_idx_o;
    logic [IDXWIDTH-1:0]  y2_idx_o;
    logic                 sign_o;
    logic                 desc_o;
    logic                 swapped_o;

    modport slave (
        input  in_valid_i, sign_i, desc_i, x1_i, x2_i, x1_idx_i, x2_idx_i, out_ready_i,
        output in_ready_o, out_valid_o, y1_o, y2_o, y1_idx_o, y2_idx_o,
               sign_o, desc_o, swapped_o
    );

    modport master (
        output in_valid_i, sign_i, desc_i, x1_i, x2_i, x1_idx_i, x2_idx_i, out_ready_i,
        input  in_ready_o, out_valid_o, y1_o, y2_o, y1_idx_o, y2_idx_o,
               sign_o, desc_o, swapped_o
    );
endinterface

// File: rtl/cas_stream.sv
// Compare-and-swap node with tag tracking, elastic valid/ready pipeline
// of PIPE_STAGES registers and a saturating swap counter.
module cas_stream #(
    parameter int DATAWIDTH   = 8,
    parameter int IDXWIDTH    = 4,
    parameter int PIPE_STAGES = 1,
    parameter int CNTWIDTH    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cas_stream_if.slave         bus,
    input  logic                clr_cnt_i,
    output logic [CNTWIDTH-1:0] swap_cnt_o
);
    typedef struct packed {
        logic [DATAWIDTH-1:0] y1;
        logic [DATAWIDTH-1:0] y2;
        logic [IDXWIDTH-1:0]  y1_idx;
        logic [IDXWIDTH-1:0]  y2_idx;
        logic                 sign;
        logic                 desc;
        logic                 swapped;
    } stage_t;

    logic [DATAWIDTH-1:0]   sign_flip;
    logic [DATAWIDTH-1:0]   key1;
    logic [DATAWIDTH-1:0]   key2;
    logic                   do_swap;
    logic                   in_fire;
    stage_t                 in_data;
    logic [PIPE_STAGES-1:0] valid_vec;
    logic [PIPE_STAGES-1:0] load_vec;
    stage_t                 data_vec [PIPE_STAGES];
    logic [CNTWIDTH-1:0]    swap_cnt_reg;

    // Flipping the MSB turns a two's-complement order into an unsigned one,
    // so one magnitude comparator serves both modes.
    assign sign_flip = {bus.sign_i, {(DATAWIDTH-1){1'b0}}};
    assign key1      = bus.x1_i ^ sign_flip;
    assign key2      = bus.x2_i ^ sign_flip;
    assign do_swap   = bus.desc_i ? (key1 < key2) : (key1 > key2);

    always_comb begin
        in_data         = '0;
        in_data.sign    = bus.sign_i;
        in_data.desc    = bus.desc_i;
        in_data.swapped = do_swap;
        if (do_swap) begin
            in_data.y1     = bus.x2_i;
            in_data.y2     = bus.x1_i;
            in_data.y1_idx = bus.x2_idx_i;
            in_data.y2_idx = bus.x1_idx_i;
        end else begin
            in_data.y1     = bus.x1_i;
            in_data.y2     = bus.x2_i;
            in_data.y1_idx = bus.x1_idx_i;
            in_data.y2_idx = bus.x2_idx_i;
        end
    end

    // Ready ripples back from the output: a stage may load when it is empty
    // or its occupant is leaving this cycle.
    always_comb begin
        logic chain;
        load_vec = '0;
        chain    = bus.out_ready_i;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            load_vec[k] = ~valid_vec[k] | chain;
            chain       = load_vec[k];
        end
    end

    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
        logic   valid_reg;
        stage_t data_reg;
        logic   src_valid;
        stage_t src_data;

        if (gi == 0) begin : g_head
            assign src_valid = bus.in_valid_i;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = valid_vec[gi-1];
            assign src_data  = data_vec[gi-1];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (load_vec[gi]) begin
                valid_reg <= src_valid;
                if (src_valid) begin
                    data_reg <= src_data;
                end
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign data_vec[gi]  = data_reg;
    end

    assign in_fire        = bus.in_valid_i & load_vec[0];
    assign bus.in_ready_o = load_vec[0];

    assign bus.out_valid_o = valid_vec[PIPE_STAGES-1];
    assign bus.y1_o        = data_vec[PIPE_STAGES-1].y1;
    assign bus.y2_o        = data_vec[PIPE_STAGES-1].y2;
    assign bus.y1_idx_o    = data_vec[PIPE_STAGES-1].y1_idx;
    assign bus.y2_idx_o    = data_vec[PIPE_STAGES-1].y2_idx;
    assign bus.sign_o      = data_vec[PIPE_STAGES-1].sign;
    assign bus.desc_o      = data_vec[PIPE_STAGES-1].desc;
    assign bus.swapped_o   = data_vec[PIPE_STAGES-1].swapped;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            swap_cnt_reg <= '0;
        end else if (in_fire && do_swap && !(&swap_cnt_reg)) begin
            swap_cnt_reg <= swap_cnt_reg + CNTWIDTH'(1);
        end
    end

    assign swap_cnt_o = swap_cnt_reg;
endmodule

// File: tb/tb_cas_stream.sv
// Scoreboard bench: dut_a (1 stage, 2-bit counter) for directed compare and
// counter cases, dut_b (3 stages) for random backpressure and mid-stream reset.
module tb_cas_stream;
    localparam int DW = 8;
    localparam int IW = 4;

    typedef logic [26:0] obs_t;  // {y1, y2, y1_idx, y2_idx, sign, desc, swapped}

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_a;
    logic        clr_b;
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    cas_stream_if #(.DATAWIDTH(DW), .IDXWIDTH(IW)) ia ();
    cas_stream_if #(.DATAWIDTH(DW), .IDXWIDTH(IW)) ib ();

    cas_stream #(.DATAWIDTH(DW), .IDXWIDTH(IW), .PIPE_STAGES(1), .CNTWIDTH(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ia), .clr_cnt_i(clr_a), .swap_cnt_o(cnt_a)
    );
    cas_stream #(.DATAWIDTH(DW), .IDXWIDTH(IW), .PIPE_STAGES(3), .CNTWIDTH(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ib), .clr_cnt_i(clr_b), .swap_cnt_o(cnt_b)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    obs_t        q_a[$];
    int          qc_a[$];
    obs_t        q_b[$];
    logic [1:0]  mc_a = '0;
    logic [15:0] mc_b = '0;
    logic        stall_b = 1'b0;
    obs_t        held_b;

    always @(posedge clk) cyc <= cyc + 1;

    wire obs_t obs_a = {ia.y1_o, ia.y2_o, ia.y1_idx_o, ia.y2_idx_o, ia.sign_o, ia.desc_o, ia.swapped_o};
    wire obs_t obs_b = {ib.y1_o, ib.y2_o, ib.y1_idx_o, ib.y2_idx_o, ib.sign_o, ib.desc_o, ib.swapped_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    function automatic obs_t model(input logic [7:0] x1, input logic [7:0] x2,
                                   input logic [3:0] i1, input logic [3:0] i2,
                                   input logic s, input logic d);
        logic gt, lt, sw;
        if (s) begin
            gt = $signed(x1) > $signed(x2);
            lt = $signed(x1) < $signed(x2);
        end else begin
            gt = x1 > x2;
            lt = x1 < x2;
        end
        sw = d ? lt : gt;
        return sw ? {x2, x1, i2, i1, s, d, 1'b1} : {x1, x2, i1, i2, s, d, 1'b0};
    endfunction

    task automatic drive(input logic b, input logic iv, input logic [7:0] x1, input logic [7:0] x2,
                         input logic [3:0] i1, input logic [3:0] i2, input logic s, input logic d);
        if (!b) begin
            ia.in_valid_i = iv; ia.x1_i = x1; ia.x2_i = x2;
            ia.x1_idx_i = i1; ia.x2_idx_i = i2; ia.sign_i = s; ia.desc_i = d;
        end else begin
            ib.in_valid_i = iv; ib.x1_i = x1; ib.x2_i = x2;
            ib.x1_idx_i = i1; ib.x2_idx_i = i2; ib.sign_i = s; ib.desc_i = d;
        end
    endtask

    task automatic cycle_a(input logic iv, input logic [7:0] x1, input logic [7:0] x2,
                           input logic [3:0] i1, input logic [3:0] i2,
                           input logic s, input logic d, input logic clr);
        obs_t e;
        @(negedge clk);
        drive(1'b0, iv, x1, x2, i1, i2, s, d);
        clr_a = clr;
        ia.out_ready_i = 1'b1;
        #1;
        check("a_in_ready", ia.in_ready_o, 1);
        check("a_cnt", cnt_a, mc_a);
        if (ia.out_valid_o) begin
            if (q_a.size() == 0) check("a_spurious_out", ia.out_valid_o, 0);
            else begin
                check("a_out", obs_a, q_a.pop_front());
                check("a_latency", cyc, qc_a.pop_front() + 1);
            end
        end
        e = model(x1, x2, i1, i2, s, d);
        if (clr) mc_a = '0;
        else if (iv && ia.in_ready_o && e[0] && mc_a != 2'b11) mc_a = mc_a + 2'd1;
        if (iv && ia.in_ready_o) begin
            q_a.push_back(e);
            qc_a.push_back(cyc);
        end
    endtask

    task automatic cycle_b(input logic iv, input logic [7:0] x1, input logic [7:0] x2,
                           input logic [3:0] i1, input logic [3:0] i2,
                           input logic s, input logic d, input logic ordy, output logic acc);
        obs_t e;
        @(negedge clk);
        if (stall_b) begin
            check("b_hold_valid", ib.out_valid_o, 1);
            check("b_hold_data", obs_b, held_b);
        end
        drive(1'b1, iv, x1, x2, i1, i2, s, d);
        clr_b = 1'b0;
        ib.out_ready_i = ordy;
        #1;
        check("b_in_ready", ib.in_ready_o, !(q_b.size() == 3 && !ordy));
        check("b_cnt", cnt_b, mc_b);
        if (ib.out_valid_o && ordy) begin
            if (q_b.size() == 0) check("b_spurious_out", ib.out_valid_o, 0);
            else check("b_out", obs_b, q_b.pop_front());
        end
        stall_b = ib.out_valid_o && !ordy;
        held_b  = obs_b;
        acc     = iv && ib.in_ready_o;
        if (acc) begin
            e = model(x1, x2, i1, i2, s, d);
            q_b.push_back(e);
            if (e[0] && mc_b != 16'hFFFF) mc_b = mc_b + 16'd1;
        end
    endtask

    initial begin
        logic acc;
        int   sent;
        int   guard;

        rst = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        ia.out_ready_i = 1'b1; ib.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_a_valid", ia.out_valid_o, 0);
        check("rst_a_data", obs_a, 0);
        check("rst_a_cnt", cnt_a, 0);
        check("rst_a_ready", ia.in_ready_o, 1);
        check("rst_b_valid", ib.out_valid_o, 0);
        check("rst_b_ready", ib.in_ready_o, 1);

        // Basic unsigned ascending swap with tags
        cycle_a(1, 8'hF0, 8'h10, 4'd3, 4'd7, 0, 0, 0);
        cycle_a(0, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0, 0);
        check("t1_y1", ia.y1_o, 8'h10);
        check("t1_y2", ia.y2_o, 8'hF0);
        check("t1_y1_idx", ia.y1_idx_o, 4'd7);
        check("t1_swapped", ia.swapped_o, 1);
        check("t1_cnt", cnt_a, 1);

        // Signed vs unsigned, descending
        cycle_a(1, 8'hF0, 8'h10, 4'd1, 4'd2, 1, 0, 0);
        cycle_a(1, 8'hF0, 8'h10, 4'd1, 4'd2, 0, 0, 0);
        cycle_a(1, 8'hF0, 8'h10, 4'd1, 4'd2, 1, 1, 0);
        cycle_a(1, 8'h05, 8'h80, 4'd4, 4'd5, 0, 1, 0);

        // Ties never swap, in either mode
        cycle_a(0, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0, 1);
        cycle_a(1, 8'h55, 8'h55, 4'd1, 4'd2, 0, 0, 0);
        cycle_a(1, 8'h55, 8'h55, 4'd1, 4'd2, 1, 1, 0);
        cycle_a(0, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0, 0);
        check("tie_cnt", cnt_a, 0);

        // Saturation, then clear beating a simultaneous swap, then idle swap data
        for (int i = 0; i < 5; i++) cycle_a(1, 8'h90, 8'h20, 4'(i), 4'd9, 0, 0, 0);
        cycle_a(0, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0, 0);
        check("sat_cnt", cnt_a, 3);
        cycle_a(1, 8'h90, 8'h20, 4'd1, 4'd2, 0, 0, 1);
        cycle_a(0, 8'h90, 8'h20, 4'd1, 4'd2, 0, 0, 0);
        cycle_a(0, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0, 0);
        check("clr_win_cnt", cnt_a, 0);
        check("a_drain", q_a.size(), 0);

        // Random backpressure through three stages
        sent = 0; guard = 0;
        while (sent < 10 && guard < 400) begin
            cycle_b(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    4'(sent), 4'(sent + 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            guard++;
        end
        check("b_sent", sent, 10);
        guard = 0;
        while (q_b.size() != 0 && guard < 50) begin
            cycle_b(0, '0, '0, '0, '0, 0, 0, 1'($urandom_range(0, 1)), acc);
            guard++;
        end
        check("b_drain", q_b.size(), 0);

        // Reset with two transactions held in the pipe
        cycle_b(1, 8'hC0, 8'h01, 4'd1, 4'd2, 0, 0, 0, acc);
        cycle_b(1, 8'hC1, 8'h02, 4'd3, 4'd4, 0, 0, 0, acc);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hFF, 8'h00, 4'd5, 4'd6, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, '0, '0, '0, '0, 0, 0);
        #1;
        check("mid_rst_valid", ib.out_valid_o, 0);
        check("mid_rst_data", obs_b, 0);
        check("mid_rst_cnt", cnt_b, 0);
        check("mid_rst_ready", ib.in_ready_o, 1);
        q_b.delete();
        mc_b = '0;
        stall_b = 1'b0;
        for (int i = 0; i < 5; i++) cycle_b(0, '0, '0, '0, '0, 0, 0, 1, acc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
